fsm_seq_ctrl: RTL and testbench

FSM_SEQ_CTRL -- requirements
Module: fsm_seq_ctrl

---
 rtl/fsm_seq_pkg.sv | 37 +++
 rtl/seq_wdog.sv | 28 ++
 rtl/fsm_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_fsm_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the sequencing controller and its target handshake.
package fsm_seq_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_ARM   = 3'd1,
    C_ADV   = 3'd2,
    C_RET   = 3'd3,
    C_CHK   = 3'd4,
    C_RECOV = 3'd5,
    C_END   = 3'd6
  } ctrl_state_e;

  // Target status as {o1, o2, err}
  localparam logic [ST_W-1:0] TST_IDLE = 3'b000;
  localparam logic [ST_W-1:0] TST_S1   = 3'b100;
  localparam logic [ST_W-1:0] TST_S2   = 3'b010;
  localparam logic [ST_W-1:0] TST_ER   = 3'b111;

  // Target drive {i1, i2} implied by a controller state
  function automatic logic [1:0] drive_of(input ctrl_state_e st);
    case (st)
      C_ARM, C_ADV: return 2'b11;
      C_RET:        return 2'b10;
      default:      return 2'b00;
    endcase
  endfunction

  function automatic logic [ERR_W-1:0] err_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/seq_wdog.sv
// Per-state wait counter; expired marks the TMO_CYC-th consecutive cycle spent in one wait state.
module seq_wdog #(
  parameter int unsigned TMO_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q;

  assign expired = tick && (cnt_q == CW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || !tick) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Drives a small target FSM through repeated IDLE->S1->S2->IDLE round trips with
// timeout, error recovery and abort handling.
module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int unsigned TMO_CYC = 8,
  parameter int unsigned MAX_ERR = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             abort,
  output logic             tgt_i1,
  output logic             tgt_i2,
  input  logic             tgt_o1,
  input  logic             tgt_o2,
  input  logic             tgt_err,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] cyc_done,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(MAX_ERR);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] tgt_cnt_q, tgt_cnt_d;
  logic [CNT_W-1:0] cyc_d, cyc_inc;
  logic [ERR_W-1:0] err_d;
  logic             abort_q, abort_d;
  logic             done_d, fail_d, busy_d;
  logic [1:0]       drv_d;
  logic [ST_W-1:0]  status;
  logic             wd_clr, wd_tick, expired;

  assign status  = {tgt_o1, tgt_o2, tgt_err};
  assign cyc_inc = cyc_done + CNT_W'(1);
  assign wd_clr  = (state_d != state_q);
  assign wd_tick = state_q inside {C_ARM, C_ADV, C_RET, C_CHK, C_RECOV};

  seq_wdog #(
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .tick    (wd_tick),
    .expired (expired)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    tgt_cnt_d = tgt_cnt_q;
    cyc_d     = cyc_done;
    err_d     = err_cnt;
    abort_d   = abort_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;

    case (state_q)
      C_IDLE: begin
        if (start) begin
          tgt_cnt_d = num_cycles;
          cyc_d     = '0;
          err_d     = '0;
          abort_d   = 1'b0;
          if (num_cycles == '0) begin
            state_d = C_END;
            done_d  = 1'b1;
          end else begin
            state_d = C_ARM;
          end
        end
      end

      C_ARM, C_ADV, C_RET, C_CHK: begin
        if (abort) begin
          abort_d = 1'b1;
          state_d = C_RECOV;
        end else if (status == TST_ER) begin
          err_d   = err_inc(err_cnt);
          state_d = C_RECOV;
        end else if (state_q == C_ARM && status == TST_S1) begin
          state_d = C_ADV;
        end else if (state_q == C_ADV && status == TST_S2) begin
          state_d = C_RET;
        end else if (state_q == C_RET) begin
          state_d = C_CHK;
        end else if (state_q == C_CHK && status == TST_IDLE) begin
          cyc_d = cyc_inc;
          if (cyc_inc == tgt_cnt_q) begin
            state_d = C_END;
            done_d  = 1'b1;
          end else begin
            state_d = C_ARM;
          end
        end else if (expired) begin
          err_d   = err_inc(err_cnt);
          state_d = C_RECOV;
        end
      end

      // Hold the target at 00 until it settles in IDLE, then retry or give up
      C_RECOV: begin
        if (abort) begin
          abort_d = 1'b1;
        end
        if (status == TST_IDLE) begin
          if (abort_q || abort || err_cnt >= ERR_LIM) begin
            state_d = C_END;
            fail_d  = 1'b1;
          end else begin
            state_d = C_ARM;
          end
        end else if (expired) begin
          state_d = C_END;
          fail_d  = 1'b1;
        end
      end

      C_END:   state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase

    busy_d = (state_d != C_IDLE);
    drv_d  = drive_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= C_IDLE;
      tgt_cnt_q <= '0;
      cyc_done  <= '0;
      err_cnt   <= '0;
      abort_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      tgt_i1    <= 1'b0;
      tgt_i2    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_cnt_q <= tgt_cnt_d;
      cyc_done  <= cyc_d;
      err_cnt   <= err_d;
      abort_q   <= abort_d;
      busy      <= busy_d;
      done      <= done_d;
      fail      <= fail_d;
      tgt_i1    <= drv_d[1];
      tgt_i2    <= drv_d[0];
    end
  end

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Directed bench for fsm_seq_ctrl against a behavioural target FSM.
module tb_fsm_seq_ctrl;
  import fsm_seq_pkg::*;

  localparam int LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] num_cycles = 8'd0;
  logic       abort = 1'b0;
  logic       tgt_i1, tgt_i2;
  logic       tgt_o1, tgt_o2, tgt_err;
  logic       busy, done, fail;
  logic [7:0] cyc_done;
  logic [3:0] err_cnt;

  // Target model controls
  logic       stuck = 1'b0;
  logic       er_req = 1'b0;
  logic       er_used;
  logic [2:0] t_st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fsm_seq_ctrl #(
    .TMO_CYC (8),
    .MAX_ERR (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_cycles (num_cycles),
    .abort      (abort),
    .tgt_i1     (tgt_i1),
    .tgt_i2     (tgt_i2),
    .tgt_o1     (tgt_o1),
    .tgt_o2     (tgt_o2),
    .tgt_err    (tgt_err),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .cyc_done   (cyc_done),
    .err_cnt    (err_cnt)
  );

  assign {tgt_o1, tgt_o2, tgt_err} = t_st;

  // Behavioural target: 11 walks IDLE->S1->S2, 10 returns S2->IDLE, 00 forces IDLE
  always @(posedge clk) begin
    if (rst) begin
      t_st    <= TST_IDLE;
      er_used <= 1'b0;
    end else begin
      if (!er_req) er_used <= 1'b0;
      if (stuck) begin
        t_st <= TST_IDLE;
      end else if (er_req && !er_used && t_st == TST_S1) begin
        t_st    <= TST_ER;
        er_used <= 1'b1;
      end else if ({tgt_i1, tgt_i2} == 2'b00) begin
        t_st <= TST_IDLE;
      end else begin
        case (t_st)
          TST_IDLE: if ({tgt_i1, tgt_i2} == 2'b11) t_st <= TST_S1;
                    else if ({tgt_i1, tgt_i2} == 2'b10) t_st <= TST_ER;
          TST_S1:   if ({tgt_i1, tgt_i2} == 2'b11) t_st <= TST_S2;
          TST_S2:   if ({tgt_i1, tgt_i2} == 2'b10) t_st <= TST_IDLE;
          default:  t_st <= t_st;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a run and follow it to its done/fail pulse; k counts edges after acceptance
  task automatic run(input int n, input int abort_k, input int restart_k, input int probe_k,
                     output int lat, output logic got_done, output logic got_fail,
                     output logic drv_seen, output logic [1:0] probe_drv, output logic busy0);
    lat = -1; got_done = 1'b0; got_fail = 1'b0; drv_seen = 1'b0;
    probe_drv = 2'bxx; busy0 = 1'b0;
    start = 1'b1;
    num_cycles = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_cycles = 8'd0;
    busy0 = busy;
    for (int k = 0; k < LIMIT; k++) begin
      if ({tgt_i1, tgt_i2} != 2'b00) drv_seen = 1'b1;
      if (k == probe_k) probe_drv = {tgt_i1, tgt_i2};
      if (done || fail) begin
        lat = k;
        got_done = done;
        got_fail = fail;
        break;
      end
      abort = (k == abort_k);
      start = (k == restart_k);
      num_cycles = start ? 8'd5 : 8'd0;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    num_cycles = 8'd0;
    if (lat < 0) chk("run_timeout", 32'(lat), 32'(n));
  endtask

  int         lat;
  logic       gd, gf, dseen, b0;
  logic [1:0] pdrv;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_cyc", 32'(cyc_done), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_drv", 32'({tgt_i1, tgt_i2}), 0);

    // Two round trips; a start mid-run must be ignored
    run(2, -1, 3, -1, lat, gd, gf, dseen, pdrv, b0);
    chk("n2_busy0", 32'(b0), 1);
    chk("n2_lat", 32'(lat), 10);
    chk("n2_done", 32'(gd), 1);
    chk("n2_fail", 32'(gf), 0);
    chk("n2_cyc", 32'(cyc_done), 2);
    chk("n2_err", 32'(err_cnt), 0);
    @(posedge clk); #1;
    chk("n2_busy_after", 32'(busy), 0);
    chk("n2_done_after", 32'(done), 0);

    // Abort while idle is ignored and counters hold
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    chk("idle_abort_busy", 32'(busy), 0);
    chk("idle_abort_fail", 32'(fail), 0);
    chk("idle_hold_cyc", 32'(cyc_done), 2);

    // Zero round trips: immediate done, no target drive
    run(0, -1, -1, -1, lat, gd, gf, dseen, pdrv, b0);
    chk("n0_lat", 32'(lat), 0);
    chk("n0_done", 32'(gd), 1);
    chk("n0_busy", 32'(b0), 1);
    chk("n0_drv", 32'(dseen), 0);
    chk("n0_cyc", 32'(cyc_done), 0);
    @(posedge clk); #1;

    // One ER during round trip 1 of 3
    er_req = 1'b1;
    run(3, -1, -1, 3, lat, gd, gf, dseen, pdrv, b0);
    er_req = 1'b0;
    chk("er_recov_drv", 32'(pdrv), 0);
    chk("er_lat", 32'(lat), 20);
    chk("er_done", 32'(gd), 1);
    chk("er_fail", 32'(gf), 0);
    chk("er_cyc", 32'(cyc_done), 3);
    chk("er_err", 32'(err_cnt), 1);
    @(posedge clk); #1;

    // Abort during ADV of round trip 2
    run(3, 7, -1, 8, lat, gd, gf, dseen, pdrv, b0);
    chk("ab_drv", 32'(pdrv), 0);
    chk("ab_lat", 32'(lat), 10);
    chk("ab_fail", 32'(gf), 1);
    chk("ab_done", 32'(gd), 0);
    chk("ab_cyc", 32'(cyc_done), 1);
    chk("ab_err", 32'(err_cnt), 0);
    @(posedge clk); #1;

    // Unresponsive target: three timeouts then fail
    stuck = 1'b1;
    run(2, -1, -1, -1, lat, gd, gf, dseen, pdrv, b0);
    stuck = 1'b0;
    chk("tmo_lat", 32'(lat), 27);
    chk("tmo_fail", 32'(gf), 1);
    chk("tmo_done", 32'(gd), 0);
    chk("tmo_err", 32'(err_cnt), 3);
    chk("tmo_cyc", 32'(cyc_done), 0);
    @(posedge clk); #1;
    chk("tmo_err_hold", 32'(err_cnt), 3);

    // Reset while in ARM, then a clean run
    start = 1'b1;
    num_cycles = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    num_cycles = 8'd0;
    chk("mr_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_drv", 32'({tgt_i1, tgt_i2}), 0);
    chk("mr_cyc_err", 32'({cyc_done, err_cnt}), 0);
    chk("mr_pulse", 32'({done, fail}), 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("mr_no_pulse", 32'({busy, done, fail}), 0);
    end
    run(1, -1, -1, -1, lat, gd, gf, dseen, pdrv, b0);
    chk("mr_lat", 32'(lat), 5);
    chk("mr_done", 32'(gd), 1);
    chk("mr_cyc", 32'(cyc_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
